// File: rtl/lcd_timing.sv
// Game Boy LCD dot/line timing: dot and LY counters, STAT mode, draw strobe,
// VBlank/STAT interrupts and the LY=LYC coincidence flag.
module lcd_timing #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned XFER_DOTS     = 172
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic       drawline,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       frame_start
);

    localparam int unsigned DOT_W = 9;
    localparam int unsigned LY_W  = 8;

    localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] OAM_END  = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] XFER_END = DOT_W'(OAM_DOTS + XFER_DOTS);
    localparam logic [LY_W-1:0]  LY_VIS   = LY_W'(VISIBLE_LINES);
    localparam logic [LY_W-1:0]  LY_LAST  = LY_W'(TOTAL_LINES - 1);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_e;

    logic [DOT_W-1:0] dot_q, dot_d;
    logic [LY_W-1:0]  ly_q, ly_d;
    mode_e            mode_q, mode_d;
    logic             run_q, run_d;
    logic             lyc_match_q, lyc_match_d;
    logic             stat_line_q, stat_line_d;
    logic             drawline_q, drawline_d;
    logic             vblank_irq_q, vblank_irq_d;
    logic             stat_irq_q, stat_irq_d;
    logic             frame_start_q, frame_start_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot_q         <= '0;
            ly_q          <= '0;
            mode_q        <= MODE_HBLANK;
            run_q         <= 1'b0;
            lyc_match_q   <= 1'b0;
            stat_line_q   <= 1'b0;
            drawline_q    <= 1'b0;
            vblank_irq_q  <= 1'b0;
            stat_irq_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            dot_q         <= dot_d;
            ly_q          <= ly_d;
            mode_q        <= mode_d;
            run_q         <= run_d;
            lyc_match_q   <= lyc_match_d;
            stat_line_q   <= stat_line_d;
            drawline_q    <= drawline_d;
            vblank_irq_q  <= vblank_irq_d;
            stat_irq_q    <= stat_irq_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next position, mode and pulses; all derived from the next position so
    // each pulse lands in the same cycle as the state it describes.
    always_comb begin
        dot_d         = '0;
        ly_d          = '0;
        run_d         = 1'b0;
        mode_d        = MODE_HBLANK;
        stat_line_d   = 1'b0;
        drawline_d    = 1'b0;
        vblank_irq_d  = 1'b0;
        frame_start_d = 1'b0;
        lyc_match_d   = (ly_q == lyc);

        if (lcd_enable) begin
            run_d = 1'b1;
            // First enabled cycle restarts at line 0, dot 0
            if (run_q) begin
                if (dot_q == DOT_LAST) begin
                    dot_d = '0;
                    ly_d  = (ly_q == LY_LAST) ? '0 : ly_q + LY_W'(1);
                end else begin
                    dot_d = dot_q + DOT_W'(1);
                    ly_d  = ly_q;
                end
            end

            if (ly_d >= LY_VIS)       mode_d = MODE_VBLANK;
            else if (dot_d < OAM_END)  mode_d = MODE_OAM;
            else if (dot_d < XFER_END) mode_d = MODE_XFER;
            else                       mode_d = MODE_HBLANK;

            drawline_d    = (ly_d < LY_VIS) && (dot_d == OAM_END);
            vblank_irq_d  = (ly_d == LY_VIS) && (dot_d == '0);
            frame_start_d = (ly_d == '0) && (dot_d == '0);

            stat_line_d = (stat_ie[0] && (mode_d == MODE_HBLANK)) ||
                          (stat_ie[1] && (mode_d == MODE_VBLANK)) ||
                          (stat_ie[2] && (mode_d == MODE_OAM))    ||
                          (stat_ie[3] && lyc_match_d);
        end

        stat_irq_d = stat_line_d && !stat_line_q;
    end

    assign drawline    = drawline_q;
    assign ly          = ly_q;
    assign mode        = mode_q;
    assign lyc_match   = lyc_match_q;
    assign vblank_irq  = vblank_irq_q;
    assign stat_irq    = stat_irq_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing.sv
// Directed bench for lcd_timing: line timing, full frame, LYC/STAT interrupts,
// display disable/re-enable and mid-line asynchronous reset.
module tb_lcd_timing;

    localparam int DPL  = 456;
    localparam int VIS  = 144;
    localparam int OAM  = 80;
    localparam int XFER = 172;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       drawline;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       lyc_match;
    logic       vblank_irq;
    logic       stat_irq;
    logic       frame_start;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lcd_timing dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_enable (lcd_enable),
        .lyc        (lyc),
        .stat_ie    (stat_ie),
        .drawline   (drawline),
        .ly         (ly),
        .mode       (mode),
        .lyc_match  (lyc_match),
        .vblank_irq (vblank_irq),
        .stat_irq   (stat_irq),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_mode(input int l, input int d);
        if (l >= VIS) return 2'd1;
        if (d < OAM) return 2'd2;
        if (d < OAM + XFER) return 2'd3;
        return 2'd0;
    endfunction

    // Checks position-derived outputs for cycle c counted from frame_start
    task automatic check_pos(input int c);
        int l;
        int d;
        l = (c / DPL) % 154;
        d = c % DPL;
        check("ly", 16'(ly), 16'(l));
        check("mode", 16'(mode), 16'(exp_mode(l, d)));
        check("drawline", 16'(drawline), 16'(l < VIS && d == OAM));
        check("vblank_irq", 16'(vblank_irq), 16'(l == VIS && d == 0));
        check("frame_start", 16'(frame_start), 16'(l == 0 && d == 0));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ly"}, 16'(ly), 16'(0));
        check({tag, "_mode"}, 16'(mode), 16'(0));
        check({tag, "_drawline"}, 16'(drawline), 16'(0));
        check({tag, "_vblank"}, 16'(vblank_irq), 16'(0));
        check({tag, "_stat_irq"}, 16'(stat_irq), 16'(0));
        check({tag, "_frame"}, 16'(frame_start), 16'(0));
    endtask

    initial begin
        int n_draw;
        int n_vb;
        int n_fs;
        int n_stat;
        logic sl;
        logic sl_prev;
        logic lm;
        logic [3:0] ie;
        logic [1:0] m;
        int l;
        int d;
        int pl;

        reset      = 1'b1;
        lcd_enable = 1'b0;
        lyc        = 8'd0;
        stat_ie    = 4'b0000;
        repeat (3) step();
        check_idle("reset");
        check("reset_lyc_match", 16'(lyc_match), 16'(0));

        // Released but disabled: counters held, lyc_match tracks 0==0
        reset = 1'b0;
        step();
        check_idle("disabled");
        check("disabled_lyc_match", 16'(lyc_match), 16'(1));

        // Enable and run to line 10, dot 79
        lcd_enable = 1'b1;
        for (int c = 0; c <= 10 * DPL + 79; c++) begin
            step();
            check_pos(c);
            check("a_stat_irq", 16'(stat_irq), 16'(0));
        end

        // Async reset one dot before drawline would fire
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset_lyc", 16'(lyc_match), 16'(0));
        step();
        check_idle("in_reset");

        // Full frame with LYC=5 / ie3, then ie0|ie2 from line 8
        lyc     = 8'd5;
        stat_ie = 4'b1000;
        reset   = 1'b0;
        n_draw  = 0;
        n_vb    = 0;
        n_fs    = 0;
        n_stat  = 0;
        sl_prev = 1'b0;
        for (int c = 0; c <= 154 * DPL; c++) begin
            step();
            check_pos(c);
            l  = (c / DPL) % 154;
            d  = c % DPL;
            pl = (c == 0) ? 0 : ((c - 1) / DPL) % 154;
            lm = (pl == 5);
            ie = (c >= 8 * DPL) ? 4'b0101 : 4'b1000;
            m  = exp_mode(l, d);
            sl = (ie[0] && m == 2'd0) || (ie[1] && m == 2'd1) ||
                 (ie[2] && m == 2'd2) || (ie[3] && lm);
            check("lyc_match", 16'(lyc_match), 16'(lm));
            check("stat_irq", 16'(stat_irq), 16'(sl && !sl_prev));
            sl_prev = sl;
            if (drawline) n_draw++;
            if (vblank_irq) n_vb++;
            if (frame_start) n_fs++;
            if (stat_irq) n_stat++;
            if (c == 65664) begin
                check("vb_ly", 16'(ly), 16'(144));
                check("vb_mode", 16'(mode), 16'(1));
                check("vb_pulse", 16'(vblank_irq), 16'(1));
            end
            if (c == 8 * DPL - 1) stat_ie = 4'b0101;
        end
        check("frame_drawlines", 16'(n_draw), 16'(144));
        check("frame_vblanks", 16'(n_vb), 16'(1));
        check("frame_starts", 16'(n_fs), 16'(2));
        check("frame_stat_irqs", 16'(n_stat), 16'(139));

        // Run on to line 50, dot 200 and drop lcd_enable
        for (int c = 1; c <= 50 * DPL + 200; c++) begin
            step();
            check_pos(c);
        end
        lcd_enable = 1'b0;
        step();
        check_idle("off");
        check("off_lyc_match", 16'(lyc_match), 16'(0));

        // While off, lyc_match keeps tracking and STAT stays quiet
        lyc     = 8'd0;
        stat_ie = 4'b1000;
        step();
        check("off_lyc_track", 16'(lyc_match), 16'(1));
        for (int i = 0; i < 998; i++) begin
            step();
            check_idle("hold");
        end

        // Re-enable: frame_start and mode 2 at once; stat line rises via LYC
        lcd_enable = 1'b1;
        step();
        check("reen_frame", 16'(frame_start), 16'(1));
        check("reen_mode", 16'(mode), 16'(2));
        check("reen_ly", 16'(ly), 16'(0));
        check("reen_stat_irq", 16'(stat_irq), 16'(1));
        check("reen_lyc_match", 16'(lyc_match), 16'(1));
        for (int c = 1; c <= OAM; c++) begin
            step();
            check_pos(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
